// File: rtl/regbus_arbiter.sv
// Round-robin arbiter sharing one 4-bit register-load bus among three writers.
// Each grant drives one cycle of bus data with a single active-low load strobe.
module regbus_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       freeze,
  input  logic [2:0] req,
  input  logic [1:0] tgt0,
  input  logic [1:0] tgt1,
  input  logic [1:0] tgt2,
  input  logic [3:0] dat0,
  input  logic [3:0] dat1,
  input  logic [3:0] dat2,
  output logic [2:0] gnt,
  output logic [3:0] bus_data,
  output logic [3:0] load_n,
  output logic       busy
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  state_t     r_state;
  logic [2:0] r_gnt;
  logic [3:0] r_bus_data;
  logic [3:0] r_load_n;
  logic [1:0] r_ptr;

  logic [2:0] w_elig;
  logic [1:0] w_o0;
  logic [1:0] w_o1;
  logic [1:0] w_o2;
  logic       w_found;
  logic [1:0] w_win;
  logic [1:0] w_tgt;
  logic [3:0] w_dat;
  logic [1:0] w_ptr_next;
  logic [3:0] w_load_n;

  // Winner search: a requester granted this cycle sits out the next edge.
  always_comb begin
    w_elig  = req & ~r_gnt & {3{~freeze}};
    w_o0    = 2'd0;
    w_o1    = 2'd1;
    w_o2    = 2'd2;
    w_found = 1'b0;
    w_win   = 2'd0;
    case (r_ptr)
      2'd1: begin
        w_o0 = 2'd1;
        w_o1 = 2'd2;
        w_o2 = 2'd0;
      end
      2'd2: begin
        w_o0 = 2'd2;
        w_o1 = 2'd0;
        w_o2 = 2'd1;
      end
      default: begin
        w_o0 = 2'd0;
        w_o1 = 2'd1;
        w_o2 = 2'd2;
      end
    endcase
    if (w_elig[w_o0]) begin
      w_found = 1'b1;
      w_win   = w_o0;
    end else if (w_elig[w_o1]) begin
      w_found = 1'b1;
      w_win   = w_o1;
    end else if (w_elig[w_o2]) begin
      w_found = 1'b1;
      w_win   = w_o2;
    end else begin
      w_found = 1'b0;
      w_win   = 2'd0;
    end
  end

  // Winner's target/data select and the pointer advance past the winner.
  always_comb begin
    w_tgt      = tgt0;
    w_dat      = dat0;
    w_ptr_next = 2'd1;
    case (w_win)
      2'd1: begin
        w_tgt      = tgt1;
        w_dat      = dat1;
        w_ptr_next = 2'd2;
      end
      2'd2: begin
        w_tgt      = tgt2;
        w_dat      = dat2;
        w_ptr_next = 2'd0;
      end
      default: begin
        w_tgt      = tgt0;
        w_dat      = dat0;
        w_ptr_next = 2'd1;
      end
    endcase
    w_load_n = ~(4'b0001 << w_tgt);
  end

  // IDLE/DRIVE state machine; bus_data deliberately holds through IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_gnt      <= 3'b000;
      r_bus_data <= 4'b0000;
      r_load_n   <= 4'b1111;
      r_ptr      <= 2'd0;
    end else if (w_found) begin
      r_state    <= S_DRIVE;
      r_gnt      <= 3'b001 << w_win;
      r_bus_data <= w_dat;
      r_load_n   <= w_load_n;
      r_ptr      <= w_ptr_next;
    end else begin
      r_state    <= S_IDLE;
      r_gnt      <= 3'b000;
      r_load_n   <= 4'b1111;
    end
  end

  assign gnt      = r_gnt;
  assign bus_data = r_bus_data;
  assign load_n   = r_load_n;
  assign busy     = (r_state == S_DRIVE);

endmodule
